tick_timebase: RTL and testbench
================================

Name: tick_timebase

Overview:
- Parametrised successor to the single fixed-rate one-second pulse counter.
- Generates a programmable base tick from the 100 MHz clock and a cascaded "second" tick every SEC_DIV base ticks.
- Maintains an elapsed-seconds count with sticky overflow, plus a free-running digit-scan index and one-hot digit enable for the multiplexed 7-segment display.
- Sits between the board clock and the display/FSM logic, replacing ad-hoc divider copies.

Parameters:
- CNT_W, 27, prescaler counter and period width (covers 100,000,000).
- DEFAULT_PERIOD, 100, prescaler period loaded at reset, in clocks.
- SEC_DIV, 10, base ticks per second tick (>=1).
- SEC_W, 8, elapsed-seconds counter width.
- NUM_DIGITS, 4, display digits scanned (>=2).
- REFRESH_DIV, 4, clocks per digit-scan step (>=1).

Ports:
- clock_100Mhz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = prescaler and second stages count; 0 = hold
- clear  in  1  synchronous clear of prescaler, second stage, elapsed count and overflow
- period_load  in  1  one-cycle strobe: latch period_i and restart prescaler
- period_i  in  CNT_W  new prescaler period in clocks
- tick_base  out  1  one-cycle pulse per prescaler period
- tick_sec  out  1  one-cycle pulse every SEC_DIV base ticks
- sec_count  out  SEC_W  elapsed second ticks, wraps
- sec_ovf  out  1  sticky: sec_count wrapped at least once
- digit_sel  out  clog2(NUM_DIGITS)  current scan digit index
- digit_en  out  NUM_DIGITS  one-hot, bit digit_sel high

Behaviour:
- Reset (async, active-high) clears all state:
  - period_reg = DEFAULT_PERIOD.
  - All counters = 0.
  - tick_base = 0, tick_sec = 0, sec_count = 0, sec_ovf = 0, digit_sel = 0.
  - digit_en = 1 (i.e. 'b0..01).
- Effective period P = max(period_reg, 1); period_reg values 0 and 1 both give a tick every cycle.
- Prescaler wrap strobe: wrap_b = enable && !clear && (pcnt >= P-1). The >= comparison makes a shortened period wrap immediately.
- Prescaler update each clock:
  - On wrap_b: pcnt <= 0.
  - Else if enable: pcnt <= pcnt + 1.
  - tick_base <= wrap_b, registered. It is high for exactly one cycle.
  - First pulse is on the cycle after the P-th enabled edge following reset. With P=100, tick_base is high on cycles 100, 200, ...
- Second stage advances only on wrap_b:
  - If scnt == SEC_DIV-1: scnt <= 0, tick_sec <= 1, sec_count <= sec_count + 1 (mod 2^SEC_W).
  - Otherwise scnt <= scnt + 1 and tick_sec <= 0.
  - tick_sec is always coincident with a tick_base pulse.
- Overflow: when sec_count wraps from all-ones to 0, sec_ovf <= 1. It clears only on reset or clear.
- enable = 0:
  - pcnt and scnt hold; tick_base and tick_sec are 0 the next cycle.
  - On re-enable, counting resumes from the held values; no phase loss.
- clear = 1 (priority over enable and period_load):
  - pcnt, scnt, sec_count and sec_ovf go to 0; ticks are 0 the next cycle.
  - period_reg is kept.
- period_load = 1 (without clear):
  - period_reg <= period_i; pcnt <= 0; no tick emitted that cycle; scnt is kept.
  - Next period measures P_new clocks from the load edge.
- Simultaneous wrap_b and period_load: the load wins and no tick is emitted.
- Scan logic:
  - Free-running; ignores enable and clear; cleared only by reset.
  - rcnt counts 0..REFRESH_DIV-1.
  - At rcnt == REFRESH_DIV-1: digit_sel <= (digit_sel == NUM_DIGITS-1) ? 0 : digit_sel + 1.
  - digit_en is registered together with digit_sel and always one-hot.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package tick_pkg holds:
  - Default constants: DEFAULT_PERIOD, SEC_DIV, REFRESH_DIV.
  - The board constant CLK_HZ = 100_000_000 and ONE_SEC_PERIOD = CLK_HZ.
  - Helper function for the digit_sel width.
- One natural sub-module, mod_n_counter: parametrised width, runtime terminal value, step-enable, sync clear, load-zero, wrap strobe output.
  - Instantiated three times: prescaler, second stage, refresh.

Test Plan:
- Reset default: reset for 3 cycles, enable=1, DEFAULT_PERIOD=100, SEC_DIV=10 -> tick_base pulses on cycles 100, 200, ...; tick_sec first pulses with the 10th tick_base (cycle 1000); sec_count=1 after it.
- Reload: period_load with period_i=5 at cycle 37 -> no tick at 37; tick_base at 42, 47, 52; load of period_i=0 -> tick every cycle.
- Enable gap: enable low for 20 cycles while pcnt=60 (P=100) -> no ticks during the gap; next tick exactly 40 enabled cycles after re-enable.
- Overflow: SEC_W=2, P=1, SEC_DIV=1 -> sec_count goes 1, 2, 3, 0; sec_ovf rises on the 0 and stays high until clear; clear zeroes sec_count and sec_ovf and keeps period_reg.
- Scan: NUM_DIGITS=4, REFRESH_DIV=4 -> digit_sel goes 0, 1, 2, 3, 0 every 4 cycles; digit_en goes 0001, 0010, 0100, 1000; unaffected by enable=0 and clear=1.
- Async reset mid-count: assert reset between edges at pcnt=50 -> all outputs go to their reset values immediately; counting restarts with period DEFAULT_PERIOD.

Source files
------------

// File: rtl/tick_pkg.sv
// Shared constants and helpers for the tick timebase.
// Board clock, default rates and counter width helper.
package tick_pkg;

    localparam int CLK_HZ          = 100_000_000;
    localparam int ONE_SEC_PERIOD  = CLK_HZ;

    localparam int DEF_PERIOD      = 100;
    localparam int DEF_SEC_DIV     = 10;
    localparam int DEF_REFRESH_DIV = 4;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_timebase_mod_n_counter.sv
// Modulo counter with runtime terminal value.
// Wrap strobe fires on the step that reaches the terminal.
module mod_n_counter import tick_pkg::*; #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         step_i,
    input  logic         clr_i,
    input  logic         zero_i,
    input  logic [W-1:0] term_i,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // A shortened terminal wraps at once thanks to >=.
    always_comb begin
        wrap_o = step_i && !clr_i && !zero_i && (cnt_q >= term_i);
    end

    // Next count: clear/zero first, then wrap or increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || zero_i) begin
            cnt_d = '0;
        end else if (wrap_o) begin
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tick_timebase.sv
// Programmable base tick, cascaded second tick,
// elapsed seconds and 7-segment digit scan.
module tick_timebase import tick_pkg::*; #(
    parameter int CNT_W          = 27,
    parameter int DEFAULT_PERIOD = DEF_PERIOD,
    parameter int SEC_DIV        = DEF_SEC_DIV,
    parameter int SEC_W          = 8,
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = DEF_REFRESH_DIV,
    parameter int DSEL_W         = sel_width(NUM_DIGITS)
) (
    input  logic                  clock_100Mhz,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  period_load,
    input  logic [CNT_W-1:0]      period_i,
    output logic                  tick_base,
    output logic                  tick_sec,
    output logic [SEC_W-1:0]      sec_count,
    output logic                  sec_ovf,
    output logic [DSEL_W-1:0]     digit_sel,
    output logic [NUM_DIGITS-1:0] digit_en
);

    localparam int SC_W = sel_width(SEC_DIV);
    localparam int RC_W = sel_width(REFRESH_DIV);

    localparam logic [SC_W-1:0]   SEC_TERM = SC_W'(SEC_DIV - 1);
    localparam logic [RC_W-1:0]   REF_TERM = RC_W'(REFRESH_DIV - 1);
    localparam logic [DSEL_W-1:0] LAST_DIG = DSEL_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      period_q;
    logic [CNT_W-1:0]      period_d;
    logic [CNT_W-1:0]      pre_term;
    logic                  pre_wrap;
    logic                  sec_wrap;
    logic                  ref_wrap;
    logic                  tick_base_q;
    logic                  tick_sec_q;
    logic [SEC_W-1:0]      sec_count_q;
    logic [SEC_W-1:0]      sec_count_d;
    logic                  sec_ovf_q;
    logic                  sec_ovf_d;
    logic [DSEL_W-1:0]     digit_sel_q;
    logic [DSEL_W-1:0]     digit_sel_d;
    logic [NUM_DIGITS-1:0] digit_en_q;
    logic [NUM_DIGITS-1:0] digit_en_d;

    // Periods 0 and 1 both mean a tick every enabled clock.
    always_comb begin
        if (period_q <= CNT_W'(1)) begin
            pre_term = '0;
        end else begin
            pre_term = period_q - CNT_W'(1);
        end
    end

    // Prescaler: a load restarts the phase and suppresses the wrap.
    mod_n_counter #(.W(CNT_W)) u_pre (
        .clk_i  (clock_100Mhz),
        .rst_i  (reset),
        .step_i (enable),
        .clr_i  (clear),
        .zero_i (period_load),
        .term_i (pre_term),
        .wrap_o (pre_wrap)
    );

    // Second stage advances once per base tick.
    mod_n_counter #(.W(SC_W)) u_sec (
        .clk_i  (clock_100Mhz),
        .rst_i  (reset),
        .step_i (pre_wrap),
        .clr_i  (clear),
        .zero_i (1'b0),
        .term_i (SEC_TERM),
        .wrap_o (sec_wrap)
    );

    // Refresh divider runs every clock, blind to enable and clear.
    mod_n_counter #(.W(RC_W)) u_ref (
        .clk_i  (clock_100Mhz),
        .rst_i  (reset),
        .step_i (1'b1),
        .clr_i  (1'b0),
        .zero_i (1'b0),
        .term_i (REF_TERM),
        .wrap_o (ref_wrap)
    );

    // Period register keeps its value across clear.
    always_comb begin
        period_d = period_q;
        if (period_load && !clear) begin
            period_d = period_i;
        end
    end

    // Elapsed seconds and sticky wrap flag.
    always_comb begin
        sec_count_d = sec_count_q;
        sec_ovf_d   = sec_ovf_q;
        if (clear) begin
            sec_count_d = '0;
            sec_ovf_d   = 1'b0;
        end else if (sec_wrap) begin
            sec_count_d = sec_count_q + SEC_W'(1);
            if (&sec_count_q) begin
                sec_ovf_d = 1'b1;
            end
        end
    end

    // Digit scan index and its one-hot enable move together.
    always_comb begin
        digit_sel_d = digit_sel_q;
        if (ref_wrap) begin
            if (digit_sel_q == LAST_DIG) begin
                digit_sel_d = '0;
            end else begin
                digit_sel_d = digit_sel_q + DSEL_W'(1);
            end
        end
        digit_en_d = NUM_DIGITS'(1) << digit_sel_d;
    end

    // Control and tick registers.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            period_q    <= CNT_W'(DEFAULT_PERIOD);
            tick_base_q <= 1'b0;
            tick_sec_q  <= 1'b0;
            sec_count_q <= '0;
            sec_ovf_q   <= 1'b0;
        end else begin
            period_q    <= period_d;
            tick_base_q <= pre_wrap;
            tick_sec_q  <= sec_wrap;
            sec_count_q <= sec_count_d;
            sec_ovf_q   <= sec_ovf_d;
        end
    end

    // Scan registers.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            digit_sel_q <= '0;
            digit_en_q  <= NUM_DIGITS'(1);
        end else begin
            digit_sel_q <= digit_sel_d;
            digit_en_q  <= digit_en_d;
        end
    end

    assign tick_base = tick_base_q;
    assign tick_sec  = tick_sec_q;
    assign sec_count = sec_count_q;
    assign sec_ovf   = sec_ovf_q;
    assign digit_sel = digit_sel_q;
    assign digit_en  = digit_en_q;

endmodule

// File: tb/tb_tick_timebase.sv
// Scoreboard bench for tick_timebase.
// Reference model counts enabled clocks, ticks and seconds directly.
module tb_tick_timebase;

    localparam int CNT_W = 27;
    localparam int DEF_P = 100;
    localparam int SDIV  = 10;
    localparam int SEC_W = 4;
    localparam int ND    = 4;
    localparam int RD    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             clr;
    logic             ld;
    logic [CNT_W-1:0] pin;
    logic             tick_base;
    logic             tick_sec;
    logic [SEC_W-1:0] sec_count;
    logic             sec_ovf;
    logic [1:0]       digit_sel;
    logic [ND-1:0]    digit_en;

    tick_timebase #(
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEF_P),
        .SEC_DIV        (SDIV),
        .SEC_W          (SEC_W),
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (RD)
    ) dut (
        .clock_100Mhz (clk),
        .reset        (rst),
        .enable       (en),
        .clear        (clr),
        .period_load  (ld),
        .period_i     (pin),
        .tick_base    (tick_base),
        .tick_sec     (tick_sec),
        .sec_count    (sec_count),
        .sec_ovf      (sec_ovf),
        .digit_sel    (digit_sel),
        .digit_en     (digit_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic tb;
        logic ts;
        int   sc;
        logic ov;
        int   ds;
        int   de;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Model state: clocks since reset, enabled clocks in the
    // current period, base ticks since clear, total seconds.
    int m_cyc;
    int m_ph;
    int m_per;
    int m_nb;
    int m_secs;

    task automatic m_reset();
        m_cyc  = 0;
        m_ph   = 0;
        m_per  = DEF_P;
        m_nb   = 0;
        m_secs = 0;
    endtask

    task automatic m_edge(input logic e, input logic c,
                          input logic l, input int p);
        exp_t x;
        int   per;
        m_cyc++;
        x.tb = 1'b0;
        x.ts = 1'b0;
        per  = (m_per < 1) ? 1 : m_per;
        if (c) begin
            m_ph   = 0;
            m_nb   = 0;
            m_secs = 0;
        end else if (l) begin
            m_per = p;
            m_ph  = 0;
        end else if (e) begin
            if (m_ph + 1 >= per) begin
                m_ph = 0;
                m_nb++;
                x.tb = 1'b1;
                if (m_nb % SDIV == 0) begin
                    x.ts = 1'b1;
                    m_secs++;
                end
            end else begin
                m_ph++;
            end
        end
        x.sc = m_secs % (1 << SEC_W);
        x.ov = (m_secs >= (1 << SEC_W));
        x.ds = (m_cyc / RD) % ND;
        x.de = 1 << x.ds;
        q.push_back(x);
    endtask

    task automatic step(input logic e, input logic c,
                        input logic l, input int p);
        en  = e;
        clr = c;
        ld  = l;
        pin = CNT_W'(p);
        @(posedge clk);
        m_edge(e, c, l, p);
        #1;
    endtask

    task automatic chk_reset(input string name);
        checks++;
        if (tick_base !== 1'b0 || tick_sec !== 1'b0 ||
            sec_count !== '0 || sec_ovf !== 1'b0 ||
            digit_sel !== 2'd0 || digit_en !== 4'b0001) begin
            failures++;
            $display("FAIL %s got tb=%b ts=%b sc=%0d ov=%b ds=%0d de=%b want 0 0 0 0 0 0001",
                     name, tick_base, tick_sec, sec_count, sec_ovf,
                     digit_sel, digit_en);
        end
    endtask

    // Monitor: one expected entry per clock edge, compared mid-cycle.
    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (tick_base !== x.tb || tick_sec !== x.ts ||
                int'(sec_count) != x.sc || sec_ovf !== x.ov ||
                int'(digit_sel) != x.ds || int'(digit_en) != x.de) begin
                failures++;
                $display("FAIL outputs t=%0t got tb=%b ts=%b sc=%0d ov=%b ds=%0d de=%b want tb=%b ts=%b sc=%0d ov=%b ds=%0d de=%0d",
                         $time, tick_base, tick_sec, sec_count, sec_ovf,
                         digit_sel, digit_en, x.tb, x.ts, x.sc, x.ov,
                         x.ds, x.de);
            end
        end
    end

    initial begin
        int r;
        rst = 1'b1;
        en  = 1'b1;
        clr = 1'b0;
        ld  = 1'b0;
        pin = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset_hold");
        rst = 1'b0;

        // Default period: ticks at 100, 200, ..., second at 1000.
        repeat (1005) step(1, 0, 0, 0);

        // Reload to 5 mid-period, then to 0.
        step(1, 1, 0, 0);
        repeat (36) step(1, 0, 0, 0);
        step(1, 0, 1, 5);
        repeat (20) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        repeat (10) step(1, 0, 0, 0);

        // Enable gap at pcnt=60 with P=100.
        step(1, 0, 1, 100);
        repeat (60) step(1, 0, 0, 0);
        repeat (20) step(0, 0, 0, 0);
        repeat (50) step(1, 0, 0, 0);

        // Scan keeps running through disable and clear.
        repeat (8) step(0, 1, 0, 0);

        // Overflow with P=1, then clear keeps the period.
        step(1, 0, 1, 1);
        repeat (200) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        repeat (20) step(1, 0, 0, 0);

        // Randomized traffic.
        repeat (2000) begin
            r = $urandom_range(0, 99);
            step(r < 75,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 12));
        end

        // Async reset between edges at pcnt=50.
        step(1, 0, 1, 100);
        repeat (50) step(1, 0, 0, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_reset("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        repeat (250) step(1, 0, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
